pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the exception-capable 5-stage MIPS core; one instance per boundary (F/D, D/E, E/M, M/W).
//  Carries payload, PC, branch-delay flag, valid bit, a merged exception code and FWD_CH forwarding channels.
//  Supports exception flush with PC redirect, downstream hold and hazard stall in hold or bubble mode.
//  Counts inserted bubbles for performance debug.
// PARAMETERS
//  DATA_W          96        payload width (IR, operands, immediate, ...), opaque to this block
//  PC_W            32        PC width
//  EXC_W           5         exception code width; 0 = no exception
//  FWD_CH          1         number of forwarding channels (5-bit addr + 32-bit data each)
//  RESET_PC        32'h3004  PC loaded on reset
//  BUBBLE_ON_STALL 1         1: stall_i inserts a bubble (D/E use); 0: stall_i holds contents (F/D use)
//  CNT_W           16        bubble counter width
// PORTS
//  clk             in   1             clock
//  reset           in   1             reset
//  flush_i         in   1             exception/eret redirect: kill stage contents
//  flush_pc_i      in   PC_W          PC stored into the bubble on flush (handler/EPC target)
//  hold_i          in   1             downstream stall (e.g. mult/div busy): freeze stage
//  stall_i         in   1             hazard stall for this boundary
//  in_valid_i      in   1             upstream instruction valid
//  in_pc_i         in   PC_W          upstream PC
//  in_bd_i         in   1             upstream instruction is in a delay slot
//  in_exc_up_i     in   EXC_W         exception code carried from earlier stages
//  in_exc_local_i  in   EXC_W         exception detected in the upstream stage this cycle
//  in_data_i       in   DATA_W        payload
//  in_fwd_addr_i   in   5*FWD_CH      forwarding register addresses, channel k at [5k+4:5k]
//  in_fwd_data_i   in   32*FWD_CH     forwarding data, channel k at [32k+31:32k]
//  cnt_clr_i       in   1             synchronous clear of bubble counter
//  out_valid_o     out  1             registered valid
//  out_pc_o        out  PC_W          registered PC
//  out_bd_o        out  1             registered delay-slot flag
//  out_exc_o       out  EXC_W         registered merged exception code
//  out_data_o      out  DATA_W        registered payload
//  out_fwd_addr_o  out  5*FWD_CH      registered forwarding addresses
//  out_fwd_data_o  out  32*FWD_CH     registered forwarding data
//  bubble_cnt_o    out  CNT_W         count of bubbles inserted by stall_i
// BEHAVIOUR
//  - Reset is synchronous, active-high; clock is clk (rising edge). All state updates on posedge clk.
//  - Reset values: valid=0, pc=RESET_PC, bd=0, exc=0, data=0, fwd addr/data=0, bubble_cnt=0.
//  - Priority per edge: reset > flush_i > hold_i > stall_i > load.
//  - flush_i: valid=0, exc=0, data=0, fwd=0, bd=0, pc=flush_pc_i. Overrides hold_i and stall_i in the same cycle.
//  - hold_i (no flush): every register keeps its value, any mode; bubble_cnt unchanged.
//  - stall_i, BUBBLE_ON_STALL=1: bubble: valid=0, exc=0, data=0, fwd=0; pc and bd KEEP current value (bubble carries
//    a valid EPC for interrupts taken on it); bubble_cnt += 1, saturating at all-ones.
//  - stall_i, BUBBLE_ON_STALL=0: hold all registers, counter unchanged.
//  - Load: all fields take inputs; exc = (in_exc_up_i!=0) ? in_exc_up_i : in_exc_local_i (oldest exception wins);
//    if in_valid_i=0 then exc, data and fwd load 0; pc and bd still load.
//  - cnt_clr_i: counter := 0, takes priority over the increment; reset also clears it; flush does not.
//  - Latency: exactly one cycle input -> output; no combinational input->output paths.
//  - Widths: fwd fields are flat vectors, channels never mixed; counter saturates, no wrap.
// STRUCTURE
//  - Shared package cpu_pipe_pkg: EXC_W, EXC_NONE=0, exception code constants (INT, AdEL, AdES, RI, Ov, ...), RESET_PC.
//  - One sub-module: pipe_fwd_slot (single addr+data channel with clear/hold/load), generated FWD_CH times.
//  - Remainder is a single always block plus the saturating counter.
// TESTING
//  - Reset 3 cycles -> valid=0, pc=32'h3004, exc=0, bubble_cnt=0; load in_pc=32'h3008,valid=1 -> next edge out_pc=32'h3008.
//  - Load in_exc_up=0, in_exc_local=5'd12 -> out_exc=12; in_exc_up=5'd4, local=5'd12 -> out_exc=4.
//  - BUBBLE_ON_STALL=1, stage pc=32'h3010, bd=1, stall 3 cycles -> valid=0, data=0, pc=32'h3010, bd=1, bubble_cnt=3.
//  - BUBBLE_ON_STALL=0, stall 2 cycles with data=32'hDEAD -> data stays 32'hDEAD, valid stays 1, counter 0.
//  - flush_i with hold_i and stall_i all high, flush_pc=32'h4180 -> valid=0, pc=32'h4180, bd=0, exc=0.
//  - CNT_W=2: stall 5 cycles -> bubble_cnt=3; cnt_clr_i with stall_i -> 0; FWD_CH=2 ch1 addr=5'd31 passes, ch0 unaffected.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: exception codes, reset PC
// and the per-edge action decode used by every inter-stage register.
package cpu_pipe_pkg;

  localparam int EXC_W = 5;
  typedef logic [EXC_W-1:0] exc_t;

  // Code 0 means "no exception", so the interrupt gets a private code instead of ExcCode 0.
  localparam exc_t EXC_NONE = 5'd0;
  localparam exc_t EXC_ADEL = 5'd4;
  localparam exc_t EXC_ADES = 5'd5;
  localparam exc_t EXC_SYS  = 5'd8;
  localparam exc_t EXC_BP   = 5'd9;
  localparam exc_t EXC_RI   = 5'd10;
  localparam exc_t EXC_OV   = 5'd12;
  localparam exc_t EXC_INT  = 5'd31;

  localparam logic [31:0] RESET_PC = 32'h0000_3004;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  function automatic stage_act_e stage_action(input logic flush, input logic hold,
                                              input logic stall, input logic bubble_mode);
    stage_act_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (hold) begin
      act = ACT_HOLD;
    end else if (stall) begin
      act = bubble_mode ? ACT_BUBBLE : ACT_HOLD;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_fwd_slot.sv
// One forwarding channel (5-bit register address + 32-bit data) of a pipeline
// register, with clear, hold and load.
module pipe_fwd_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        hold_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [4:0]  addr_o,
  output logic [31:0] data_o
);

  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  // Next-state selection: clear wins over hold, hold wins over load.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (clr_i) begin
      addr_d = 5'd0;
      data_d = 32'd0;
    end else if (hold_i) begin
      addr_d = addr_q;
      data_d = data_q;
    end else begin
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= 5'd0;
      data_q <= 32'd0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with exception merge, flush/redirect, hold,
// hazard stall (hold or bubble) and a saturating bubble counter.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W          = 96,
  parameter int                PC_W            = 32,
  parameter int                EXC_W           = cpu_pipe_pkg::EXC_W,
  parameter int                FWD_CH          = 1,
  parameter logic [PC_W-1:0]   RESET_PC        = cpu_pipe_pkg::RESET_PC,
  parameter int                BUBBLE_ON_STALL = 1,
  parameter int                CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic [PC_W-1:0]       flush_pc_i,
  input  logic                  hold_i,
  input  logic                  stall_i,
  input  logic                  in_valid_i,
  input  logic [PC_W-1:0]       in_pc_i,
  input  logic                  in_bd_i,
  input  logic [EXC_W-1:0]      in_exc_up_i,
  input  logic [EXC_W-1:0]      in_exc_local_i,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic [5*FWD_CH-1:0]   in_fwd_addr_i,
  input  logic [32*FWD_CH-1:0]  in_fwd_data_i,
  input  logic                  cnt_clr_i,
  output logic                  out_valid_o,
  output logic [PC_W-1:0]       out_pc_o,
  output logic                  out_bd_o,
  output logic [EXC_W-1:0]      out_exc_o,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [5*FWD_CH-1:0]   out_fwd_addr_o,
  output logic [32*FWD_CH-1:0]  out_fwd_data_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  localparam logic BUBBLE_MODE = (BUBBLE_ON_STALL != 0);

  stage_act_e act_s;
  logic       fwd_clr_s;
  logic       fwd_hold_s;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic              bd_q,    bd_d;
  logic [EXC_W-1:0]  exc_q,   exc_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  assign act_s      = stage_action(flush_i, hold_i, stall_i, BUBBLE_MODE);
  // An invalid upstream slot must not leave stale forwarding info behind.
  assign fwd_clr_s  = (act_s == ACT_FLUSH) || (act_s == ACT_BUBBLE) ||
                      ((act_s == ACT_LOAD) && !in_valid_i);
  assign fwd_hold_s = (act_s == ACT_HOLD);

  for (genvar k = 0; k < FWD_CH; k++) begin : g_fwd
    pipe_fwd_slot u_slot (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (fwd_clr_s),
      .hold_i (fwd_hold_s),
      .addr_i (in_fwd_addr_i[5*k +: 5]),
      .data_i (in_fwd_data_i[32*k +: 32]),
      .addr_o (out_fwd_addr_o[5*k +: 5]),
      .data_o (out_fwd_data_o[32*k +: 32])
    );
  end

  // Stage field next-state; a bubble keeps pc/bd so it still carries a usable EPC.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    data_d  = data_q;
    case (act_s)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        pc_d    = flush_pc_i;
        bd_d    = 1'b0;
        exc_d   = {EXC_W{1'b0}};
        data_d  = {DATA_W{1'b0}};
      end
      ACT_HOLD: begin
        valid_d = valid_q;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        exc_d   = {EXC_W{1'b0}};
        data_d  = {DATA_W{1'b0}};
      end
      ACT_LOAD: begin
        valid_d = in_valid_i;
        pc_d    = in_pc_i;
        bd_d    = in_bd_i;
        if (in_valid_i) begin
          exc_d  = (in_exc_up_i != {EXC_W{1'b0}}) ? in_exc_up_i : in_exc_local_i;
          data_d = in_data_i;
        end else begin
          exc_d  = {EXC_W{1'b0}};
          data_d = {DATA_W{1'b0}};
        end
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  // Bubble counter: clear beats increment; saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((act_s == ACT_BUBBLE) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
      exc_q   <= {EXC_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_pc_o     = pc_q;
  assign out_bd_o     = bd_q;
  assign out_exc_o    = exc_q;
  assign out_data_o   = data_q;
  assign bubble_cnt_o = cnt_q;

endmodule
